// File: rtl/vote_report_tx.sv
// Vote report transmitter: on a 0->1 edge of mode it snapshots the four counts,
// picks a winner, and streams a 9-byte checksummed frame over a valid/ready byte link.
module vote_report_tx #(
    parameter logic [7:0] SOF_BYTE = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic [7:0] cand1_vote,
    input  logic [7:0] cand2_vote,
    input  logic [7:0] cand3_vote,
    input  logic [7:0] cand4_vote,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       report_busy,
    output logic       report_done
);

    typedef enum logic [1:0] {IDLE, COMPARE, SEND} state_t;

    state_t          state_q;
    logic            mode_d_q;
    logic            armed_q;
    logic [3:0][7:0] snap_q;
    logic [9:0]      total_q;
    logic [7:0]      best_q;
    logic [2:0]      idx_q;
    logic            tie_q;
    logic [1:0]      cmp_cnt_q;
    logic [3:0]      byte_idx_q;

    logic [7:0] cur_vote;
    logic [7:0] winner;
    logic [7:0] checksum;
    logic [3:0] sel_idx;
    logic [7:0] sel_byte;
    logic       request;

    // armed_q stays low after reset until mode is seen low, so a mode held
    // high across reset release cannot fake a rising edge.
    assign request  = mode && !mode_d_q && armed_q;
    assign cur_vote = snap_q[cmp_cnt_q];
    assign winner   = (best_q == 8'd0) ? 8'h00 :
                      tie_q            ? 8'hFF : {5'b0, idx_q};
    assign checksum = snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3] ^
                      {6'b0, total_q[9:8]} ^ total_q[7:0] ^ winner;
    assign sel_idx  = byte_idx_q + 4'd1;

    always_comb begin
        sel_byte = 8'h00;
        case (sel_idx)
            4'd1:    sel_byte = snap_q[0];
            4'd2:    sel_byte = snap_q[1];
            4'd3:    sel_byte = snap_q[2];
            4'd4:    sel_byte = snap_q[3];
            4'd5:    sel_byte = {6'b0, total_q[9:8]};
            4'd6:    sel_byte = total_q[7:0];
            4'd7:    sel_byte = winner;
            4'd8:    sel_byte = checksum;
            default: sel_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_d_q    <= 1'b0;
            armed_q     <= 1'b0;
            snap_q      <= '0;
            total_q     <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            tie_q       <= 1'b0;
            cmp_cnt_q   <= '0;
            byte_idx_q  <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            report_busy <= 1'b0;
            report_done <= 1'b0;
        end else begin
            mode_d_q    <= mode;
            report_done <= 1'b0;
            if (!mode)
                armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (request) begin
                        snap_q      <= {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
                        total_q     <= '0;
                        cmp_cnt_q   <= '0;
                        report_busy <= 1'b1;
                        state_q     <= COMPARE;
                    end
                end
                COMPARE: begin
                    total_q   <= total_q + {2'b0, cur_vote};
                    cmp_cnt_q <= cmp_cnt_q + 2'd1;
                    if (cmp_cnt_q == 2'd0) begin
                        best_q <= cur_vote;
                        idx_q  <= 3'd1;
                        tie_q  <= 1'b0;
                    end else if (cur_vote > best_q) begin
                        best_q <= cur_vote;
                        idx_q  <= {1'b0, cmp_cnt_q} + 3'd1;
                        tie_q  <= 1'b0;
                    end else if (cur_vote == best_q) begin
                        tie_q  <= 1'b1;
                    end
                    if (cmp_cnt_q == 2'd3)
                        state_q <= SEND;
                end
                SEND: begin
                    // First SEND cycle only loads SOF; best/tie are final by then.
                    if (!tx_valid) begin
                        tx_valid   <= 1'b1;
                        tx_data    <= SOF_BYTE;
                        byte_idx_q <= '0;
                    end else if (tx_ready) begin
                        if (byte_idx_q == 4'd8) begin
                            tx_valid    <= 1'b0;
                            tx_data     <= 8'h00;
                            report_busy <= 1'b0;
                            report_done <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            byte_idx_q <= sel_idx;
                            tx_data    <= sel_byte;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_report_tx.sv
// Directed bench for vote_report_tx: frame contents, latency, backpressure,
// ignored mid-frame events, back-to-back requests and asynchronous reset.
module tb_vote_report_tx;

    logic       clock;
    logic       reset;
    logic       mode;
    logic [7:0] cand1_vote, cand2_vote, cand3_vote, cand4_vote;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       report_busy;
    logic       report_done;

    int checks = 0;
    int errors = 0;

    vote_report_tx #(.SOF_BYTE(8'hA5)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .cand1_vote(cand1_vote), .cand2_vote(cand2_vote),
        .cand3_vote(cand3_vote), .cand4_vote(cand4_vote),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .report_busy(report_busy), .report_done(report_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cands(input logic [7:0] a, b, c, d);
        cand1_vote = a; cand2_vote = b; cand3_vote = c; cand4_vote = d;
    endtask

    // fr holds byte 0 (SOF) in its top byte.
    task automatic send_frame(input string nm, input logic [7:0] a, b, c, d,
                              input logic [71:0] fr, input int stall_at,
                              input bit b2b, input bit skip_req, input bit disturb);
        int n, got, cyc, stalled;
        if (!skip_req) begin
            set_cands(a, b, c, d);
            mode = 1'b0;
            tick(); tick();
            mode = 1'b1;
            tick();
            chk({nm, "_busy_set"}, report_busy, 1);
            if (disturb) set_cands(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        end
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, n, 5);
        got = 0; cyc = 0; stalled = 0;
        while (got < 9 && cyc < 60) begin
            if (got == stall_at && stalled < 3) begin
                tx_ready = 1'b0;
                stalled++;
                chk({nm, "_hold_valid"}, tx_valid, 1);
                chk({nm, "_hold_data"}, tx_data, fr[8*(8-got) +: 8]);
            end else begin
                tx_ready = 1'b1;
            end
            if (disturb && got == 3) begin
                mode = 1'b0;
                set_cands(8'h55, 8'h55, 8'h55, 8'h55);
            end
            if (disturb && got == 5) mode = 1'b1;
            if (b2b && got == 8) mode = 1'b0;
            if (tx_valid && tx_ready) begin
                chk($sformatf("%s_byte%0d", nm, got), tx_data, fr[8*(8-got) +: 8]);
                got++;
            end else if (tx_ready) begin
                chk({nm, "_valid_gap"}, tx_valid, 1);
            end
            tick();
            cyc++;
        end
        tx_ready = 1'b1;
        chk({nm, "_byte_count"}, got, 9);
        chk({nm, "_done_pulse"}, report_done, 1);
        chk({nm, "_valid_off"}, tx_valid, 0);
        chk({nm, "_busy_off"}, report_busy, 0);
        if (b2b) mode = 1'b1;
        tick();
        chk({nm, "_done_once"}, report_done, 0);
        chk({nm, "_busy_after"}, report_busy, {31'b0, b2b});
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; tx_ready = 1'b1;
        set_cands(8'h00, 8'h00, 8'h00, 8'h00);
        #3 reset = 1'b0;
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", report_busy, 0);
        chk("rst_done", report_done, 0);
        chk("rst_data", tx_data, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        send_frame("f3725", 8'd3, 8'd7, 8'd2, 8'd5, 72'hA5_03_07_02_05_00_11_02_10, -1, 0, 0, 0);
        // Stall on c2, then re-request in the report_done cycle.
        send_frame("stall", 8'd3, 8'd7, 8'd2, 8'd5, 72'hA5_03_07_02_05_00_11_02_10, 2, 1, 0, 0);
        send_frame("b2b", 8'd3, 8'd7, 8'd2, 8'd5, 72'hA5_03_07_02_05_00_11_02_10, -1, 0, 1, 0);
        send_frame("tie", 8'd9, 8'd9, 8'd1, 8'd0, 72'hA5_09_09_01_00_00_13_FF_ED, -1, 0, 0, 0);
        send_frame("zero", 8'h00, 8'h00, 8'h00, 8'h00, 72'hA5_00_00_00_00_00_00_00_00, -1, 0, 0, 0);
        send_frame("max", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 72'hA5_FF_FF_FF_FF_03_FC_FF_00, -1, 0, 0, 0);
        send_frame("dist", 8'd3, 8'd7, 8'd2, 8'd5, 72'hA5_03_07_02_05_00_11_02_10, -1, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            chk("dist_no_second", tx_valid, 0);
            tick();
        end

        // Reset in the middle of SEND, mode held high through release.
        set_cands(8'd3, 8'd7, 8'd2, 8'd5);
        mode = 1'b0;
        tick(); tick();
        mode = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_valid", tx_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_busy", report_busy, 0);
        chk("mid_rst_done", report_done, 0);
        chk("mid_rst_data", tx_data, 0);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("post_rst_valid", tx_valid, 0);
            chk("post_rst_busy", report_busy, 0);
        end
        send_frame("recover", 8'd9, 8'd9, 8'd1, 8'd0, 72'hA5_09_09_01_00_00_13_FF_ED, -1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_report_tx.md
VOTE_REPORT_TX -- requirements
Module: vote_report_tx

Interface
REQ-001 The block SHALL have parameter SOF_BYTE, default 8'hA5, meaning the start-of-frame byte sent first in every report.
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port mode, input, 1, where 0 = voting and 1 = result display; a 0->1 transition requests a report.
REQ-005 The block SHALL have ports cand1_vote, cand2_vote, cand3_vote, cand4_vote, input, 8 each, the live vote counts from the vote counter.
REQ-006 The block SHALL have port tx_data, output, 8, the current frame byte.
REQ-007 The block SHALL have port tx_valid, output, 1, which is high when tx_data holds a byte to transfer.
REQ-008 The block SHALL have port tx_ready, input, 1, which is high when the downstream serial transmitter accepts a byte.
REQ-009 The block SHALL have port report_busy, output, 1, which is high while a report is in progress.
REQ-010 The block SHALL have port report_done, output, 1, a one-cycle pulse after the final byte transfers.

Function
REQ-011 The block SHALL register mode into mode_d, and a request SHALL be the condition mode=1 and mode_d=0 sampled at a rising clock edge.
REQ-012 The FSM SHALL have states IDLE, COMPARE and SEND.
REQ-013 In IDLE, the request edge SHALL snapshot all four counts, set report_busy=1 and enter COMPARE; later count changes SHALL NOT affect the frame.
REQ-014 COMPARE SHALL take exactly 4 cycles, one snapshot per cycle in order 1..4, and SHALL accumulate a 10-bit zero-extended total.
REQ-015 COMPARE cycle 1 SHALL set best=c1, idx=1 and tie=0.
REQ-016 COMPARE for k=2..4 SHALL set best=ck, idx=k and tie=0 if ck>best, else SHALL set tie=1 if ck==best.
REQ-017 The winner code SHALL be 8'h00 if best==0, else 8'hFF if tie=1, else idx (8'h01..8'h04).
REQ-018 The first tx_valid=1 (tx_data=SOF_BYTE) SHALL occur exactly 5 cycles after the snapshot edge.
REQ-019 The frame SHALL be 9 bytes in this order: SOF_BYTE, c1, c2, c3, c4, {6'b0,total[9:8]}, total[7:0], winner, checksum.
REQ-020 The checksum SHALL be the XOR of bytes 2..8, excluding SOF_BYTE.
REQ-021 A byte SHALL transfer on an edge where tx_valid=1 and tx_ready=1; the next byte SHALL be presented on the following cycle, so 9 transfers take 9 cycles with tx_ready held high.
REQ-022 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL remain high, and no byte SHALL be skipped or repeated.
REQ-023 tx_valid SHALL never be high outside SEND.
REQ-024 On the edge transferring the checksum, the FSM SHALL go to IDLE with tx_valid=0 and report_busy=0, and report_done SHALL be 1 for exactly the next cycle.
REQ-025 Request edges during COMPARE or SEND SHALL be ignored and SHALL NOT be queued.
REQ-026 mode returning to 0 mid-report SHALL NOT abort the frame.
REQ-027 A request SHALL be accepted in the same cycle that report_done is high.
REQ-028 The total SHALL not overflow: the maximum 4*255=1020 SHALL be sent as 8'h03, 8'hFC.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock, force state=IDLE, mode_d=0, tx_valid=0, tx_data=8'h00, report_busy=0, report_done=0, and clear the snapshot, total, best, idx and tie.
REQ-030 Reset asserted mid-report SHALL abort the frame with no further bytes, and after release the block SHALL wait for a new 0->1 mode edge.
REQ-031 If mode is already 1 at reset release, no report SHALL start until mode falls and rises again.

Verification
REQ-032 Reset: assert reset=0 mid-SEND -> tx_valid, report_busy and report_done all 0 before the next clock edge, and no report after release while mode stays 1.
REQ-033 Counts 3,7,2,5 with tx_ready=1 and mode 0->1 -> after 5 cycles, 9 consecutive bytes A5,03,07,02,05,00,11,02,10, then report_done pulse.
REQ-034 Counts 9,9,1,0 -> winner FF, frame A5,09,09,01,00,00,13,FF,ED.
REQ-035 Counts all 0 -> frame A5,00,00,00,00,00,00,00,00; counts all FF -> frame A5,FF,FF,FF,FF,03,FC,FF,00.
REQ-036 Backpressure: tx_ready=0 for 3 cycles while byte c2 is presented -> tx_data=07 held, sequence complete and unduplicated after release.
REQ-037 Mid-frame events: toggle mode 1->0->1 mid-frame and change cand inputs -> ignored, frame equals original snapshot, exactly one frame sent.
